// File: rtl/csa_pkg.sv
// Shared constants and state encoding for the carry-save resolver.
package csa_pkg;

    parameter int unsigned DefaultWidth = 64;
    parameter int unsigned DefaultSlice = 16;

    // Encoding is fixed: IDLE=0, BUSY=1, DONE=2.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/csa_resolve_if.sv
// Valid/ready bus for the resolver: operand pair in, binary result out.
interface csa_resolve_if #(
    parameter int unsigned WIDTH = csa_pkg::DefaultWidth
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_s;
    logic [WIDTH-1:0] in_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    // Producer/consumer side (drives operands, accepts results).
    modport master (
        output in_valid, in_s, in_c, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    // Resolver side.
    modport slave (
        input  in_valid, in_s, in_c, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );

endinterface

// File: rtl/csa_slice_add.sv
// SLICE-bit binary adder with carry in/out; one instance is reused every cycle.
module csa_slice_add #(
    parameter int unsigned SLICE = csa_pkg::DefaultSlice
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    // Widen by one bit so the carry out falls into the top position.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
    end

endmodule

// File: rtl/csa_resolve.sv
// Multi-cycle carry-propagate resolver: converts a carry-save (sum, carry) pair
// into a binary word, resolving SLICE bits per cycle. WIDTH must be a multiple of SLICE.
module csa_resolve
    import csa_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned SLICE = DefaultSlice
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    csa_resolve_if.slave  bus,
    output logic          busy
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef logic [IdxW-1:0] idx_t;

    localparam idx_t LastIdx = idx_t'(NSLICE - 1);

    state_e           state_q, state_d;
    idx_t             idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [SLICE-1:0] sl_a, sl_b, sl_sum;
    logic             sl_cout;

    // Current slice of the latched operands feeds the shared adder.
    always_comb begin
        sl_a = s_q[idx_q * SLICE +: SLICE];
        sl_b = c_q[idx_q * SLICE +: SLICE];
    end

    csa_slice_add #(
        .SLICE (SLICE)
    ) u_slice_add (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    // Next-state: accept in IDLE, one slice per BUSY cycle, hold result in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        s_d     = s_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    s_d     = bus.in_s;
                    c_d     = bus.in_c;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                sum_d[idx_q * SLICE +: SLICE] = sl_sum;
                carry_d = sl_cout;
                idx_d   = idx_q + idx_t'(1);
                if (idx_q == LastIdx) begin
                    cout_d  = sl_cout;
                    idx_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Flush beats everything; the visible result registers are left untouched.
        if (flush) begin
            state_d = StIdle;
            idx_d   = '0;
            carry_d = 1'b0;
            s_d     = s_q;
            c_d     = c_q;
            sum_d   = sum_q;
            cout_d  = cout_q;
        end
    end

    // State, counter, operand and result registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            c_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Handshake outputs decode straight from the state register.
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.out_sum   = sum_q;
        bus.out_cout  = cout_q;
        busy          = (state_q == StBusy) || (state_q == StDone);
    end

endmodule

// File: tb/tb_csa_resolve.sv
// Directed and random bench for csa_resolve with an in-order result scoreboard.
module tb_csa_resolve;

    localparam int unsigned W = 64;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic flush = 1'b0;
    logic busy;
    logic rand_mode = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [W:0] sb[$];

    csa_resolve_if #(.WIDTH(W)) bus ();

    csa_resolve #(
        .WIDTH (W),
        .SLICE (16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Result monitor: every completed output handshake is checked against the queue head.
    always @(negedge clk) begin
        if (resetn && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_result observed=%h expected=none",
                       {bus.out_cout, bus.out_sum});
            end else begin
                check("result", {bus.out_cout, bus.out_sum}, sb.pop_front());
            end
        end
    end

    task automatic send(input logic [W-1:0] s, input logic [W-1:0] c, input logic [W:0] exp);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_s     = s;
        bus.in_c     = c;
        while (n < 50) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
        end
        if (n >= 50) begin
            check("accept_timeout", 65'(bus.in_ready), 65'(1));
        end else begin
            @(posedge clk);
            sb.push_back(exp);
            #1;
            acc_cyc = cyc;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_sc(input logic [W-1:0] s, input logic [W-1:0] c);
        logic [W:0] e;
        e = {1'b0, s} + {1'b0, c};
        send(s, c, e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        bus.out_ready = 1'b0;
        check("drain_empty", 65'(sb.size()), 65'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b, c, cs_s, cs_c, bp_sum;
        logic [W:0]   sc, e;
        int           hs_cyc, nv;

        bus.in_valid  = 1'b0;
        bus.in_s      = '0;
        bus.in_c      = '0;
        bus.out_ready = 1'b0;

        // Reset values while held in reset.
        #12;
        check("rst_in_ready", 65'(bus.in_ready), 65'(1));
        check("rst_out_valid", 65'(bus.out_valid), 65'(0));
        check("rst_busy", 65'(busy), 65'(0));
        check("rst_result", {bus.out_cout, bus.out_sum}, 65'(0));
        @(posedge clk);
        #1 resetn = 1'b1;

        // Reset asserted mid-BUSY clears everything at once; result never appears.
        send_sc(64'hFFFF_0000_1234_5678, 64'h0000_FFFF_0000_1110);
        @(posedge clk);
        #1;
        check("pre_rst_busy", 65'(busy), 65'(1));
        resetn = 1'b0;
        #1;
        check("midrst_in_ready", 65'(bus.in_ready), 65'(1));
        check("midrst_out_valid", 65'(bus.out_valid), 65'(0));
        check("midrst_busy", 65'(busy), 65'(0));
        check("midrst_result", {bus.out_cout, bus.out_sum}, 65'(0));
        sb.delete();
        @(posedge clk);
        #1 resetn = 1'b1;
        bus.out_ready = 1'b1;
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) nv++;
        end
        check("midrst_no_result", 65'(nv), 65'(0));
        @(posedge clk);
        #1 bus.out_ready = 1'b0;

        // Simple add with latency check: DONE first visible after edge k+4.
        send_sc(64'h5, 64'h3);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) check("lat_k3_not_valid", 65'(bus.out_valid), 65'(0));
            if (i == 4) check("lat_k4_valid", 65'(bus.out_valid), 65'(1));
        end
        check("simple_value", {bus.out_cout, bus.out_sum}, 65'h0_0000_0000_0000_0008);
        drain();

        // Full ripple through every slice.
        send_sc(64'hFFFF_FFFF_FFFF_FFFF, 64'h2);
        drain();

        // Backpressure in DONE with a new input waiting.
        send_sc(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        bp_sum = 64'h0123_4567_89AB_CDEF + 64'hFEDC_BA98_7654_3210;
        nv = 0;
        while (!bus.out_valid && nv < 20) begin
            @(negedge clk);
            nv++;
        end
        bus.in_valid = 1'b1;
        bus.in_s     = 64'hAAAA;
        bus.in_c     = 64'h5555;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 65'(bus.out_valid), 65'(1));
            check("bp_in_ready", 65'(bus.in_ready), 65'(0));
            check("bp_value", {bus.out_cout, bus.out_sum}, {1'b0, bp_sum});
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        bus.out_ready = 1'b0;
        check("bp_released_in_ready", 65'(bus.in_ready), 65'(1));
        send_sc(64'hAAAA, 64'h5555);
        check("bp_next_accept_cycle", 65'(acc_cyc), 65'(hs_cyc + 1));
        drain();

        // Flush in the second BUSY cycle, with a coincident in_valid.
        send_sc(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF);
        @(posedge clk);
        #1;
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_s = 64'h77;
        bus.in_c = 64'h11;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_in_ready", 65'(bus.in_ready), 65'(1));
        check("flush_busy", 65'(busy), 65'(0));
        sb.delete();
        bus.out_ready = 1'b1;
        nv = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) nv++;
        end
        check("flush_no_result", 65'(nv), 65'(0));
        @(posedge clk);
        #1 bus.out_ready = 1'b0;

        // Flush in IDLE blocks a coincident in_valid.
        flush = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_idle_not_accepted", 65'(busy), 65'(0));
        send_sc(64'h1234, 64'h10);
        drain();

        // Random triples through a 3:2 compressor model, with random output stalls.
        rand_mode = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            c = {$urandom, $urandom};
            if (i < 8) begin
                a = '1;
                b = '1;
            end
            cs_s = a ^ b ^ c;
            cs_c = ((a & b) | (a & c) | (b & c)) << 1;
            sc   = {1'b0, cs_s} + {1'b0, cs_c};
            e    = {sc[W], a + b + c};
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(cs_s, cs_c, e);
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #2;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
